// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: byte FIFO feeding a start/8N/opt-even-parity/stop serialiser.
module uart_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_i,
  input  logic                             tx_enable_i,
  input  logic [31:0]                      clk_div_i,
  input  logic                             parity_en_i,
  input  logic [7:0]                       tx_data_i,
  input  logic                             tx_valid_i,
  output logic                             tx_ready_o,
  output logic                             tx_busy_o,
  output logic                             tx_done_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
  output logic                             tx_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          full, empty, push, pop;

  state_t        state_q, state_d;
  logic [31:0]   baud_q, baud_d;
  logic [31:0]   div_q, div_d;
  logic          par_en_q, par_en_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          tick, launch;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign push  = tx_valid_i && !full;
  assign tick  = (baud_q == div_q);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data_i;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      div_q     <= div_d;
      par_en_q  <= par_en_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = tick ? 32'd0 : baud_q + 32'd1;
    div_d     = div_q;
    par_en_d  = par_en_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    launch    = 1'b0;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        launch = tx_enable_i && !empty;
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          par_d   = par_q ^ shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            tx_d    = par_en_q ? (par_q ^ shift_q[0]) : 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          launch  = tx_enable_i && !empty;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Disable wins over everything: drop the frame, keep the FIFO.
    if (!tx_enable_i) begin
      state_d = S_IDLE;
      tx_d    = 1'b1;
      baud_d  = '0;
      done_d  = 1'b0;
      launch  = 1'b0;
    end

    if (launch) begin
      pop       = 1'b1;
      state_d   = S_START;
      shift_d   = mem_q[rd_ptr_q];
      div_d     = clk_div_i;
      par_en_d  = parity_en_i;
      baud_d    = '0;
      par_d     = 1'b0;
      bit_cnt_d = '0;
      tx_d      = 1'b0;
    end
  end

  assign tx_ready_o   = !full;
  assign tx_busy_o    = (state_q != S_IDLE);
  assign tx_done_o    = done_q;
  assign fifo_level_o = level_q;
  assign tx_o         = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx: vector table, corner sequences, random bursts.
module tb_uart_tx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        tx_enable_i;
  logic [31:0] clk_div_i;
  logic        parity_en_i;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic        tx_busy_o;
  logic        tx_done_o;
  logic [$clog2(DEPTH+1)-1:0] fifo_level_o;
  logic        tx_o;

  uart_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_i(rst_i), .tx_enable_i(tx_enable_i), .clk_div_i(clk_div_i),
    .parity_en_i(parity_en_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .tx_busy_o(tx_busy_o), .tx_done_o(tx_done_o),
    .fifo_level_o(fifo_level_o), .tx_o(tx_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin
    if (tx_done_o) done_cnt++;
    if (tx_busy_o) busy_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  data;
    int          div;
    bit          par;
    int          grp;
    logic [10:0] frame;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference frame as a line sequence, element 0 sent first.
  function automatic logic [10:0] model_frame(input logic [7:0] d, input bit p);
    logic par_bit;
    par_bit = ($countones(d) % 2) == 1;
    if (p) return {1'b1, par_bit, d, 1'b0};
    return {1'b0, 1'b1, d, 1'b0};
  endfunction

  task automatic push(input logic [7:0] d);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    @(negedge clk);
    tx_valid_i = 1'b0;
  endtask

  // Checks one frame cycle by cycle, decodes it like a receiver, and leaves the
  // bench on the negedge just after the stop bit where tx_done_o must be high.
  task automatic check_frame(input logic [7:0] d, input int div, input bit par,
                             input logic [10:0] frame, input int exp_wait,
                             input int nxt_div, input bit nxt_par);
    int n;
    int len;
    int k;
    logic [7:0] rx;
    logic rxp;
    logic seen;
    n = 0;
    k = 0;
    rx = '0;
    rxp = 1'b0;
    len = par ? 11 : 10;
    while (tx_o !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("start_wait", n, exp_wait);
    if (tx_o !== 1'b0) return;
    for (int i = 0; i < len; i++) begin
      seen = frame[i];
      for (int c = 0; c <= div; c++) begin
        if (i > 0 || c > 0) begin
          @(negedge clk);
          k++;
        end
        if (k == 1) begin
          clk_div_i   = nxt_div;
          parity_en_i = nxt_par;
        end
        if (tx_o !== frame[i]) seen = tx_o;
        if (c == div / 2) begin
          if (i >= 1 && i <= 8) rx[i-1] = tx_o;
          if (i == 9 && par) rxp = tx_o;
        end
      end
      check($sformatf("bit%0d_of_%02h", i, d), seen, frame[i]);
    end
    check("rx_byte", rx, d);
    if (par) check("rx_parity_err", rxp != (($countones(rx) % 2) == 1), 1'b0);
    @(negedge clk);
    check("done_pulse", tx_done_o, 1'b1);
  endtask

  initial begin
    int first, cnt, d0, n, nb;
    logic [7:0] bd [4];
    int bdiv [4];
    bit bpar [4];
    logic line_ok;

    tbl[0] = '{8'hA5, 3, 1'b0, 0, 11'h34A};
    tbl[1] = '{8'hA5, 3, 1'b1, 1, 11'h54A};
    tbl[2] = '{8'h07, 3, 1'b1, 1, 11'h60E};
    tbl[3] = '{8'h00, 8, 1'b1, 2, 11'h400};
    tbl[4] = '{8'hFF, 8, 1'b1, 2, 11'h5FE};
    tbl[5] = '{8'h55, 8, 1'b1, 2, 11'h4AA};
    tbl[6] = '{8'h80, 8, 1'b1, 2, 11'h700};

    rst_i = 1'b1;
    tx_enable_i = 1'b0;
    clk_div_i = 32'd3;
    parity_en_i = 1'b0;
    tx_data_i = '0;
    tx_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx_o, 1'b1);
    check("rst_ready", tx_ready_o, 1'b1);
    check("rst_busy", tx_busy_o, 1'b0);
    check("rst_done", tx_done_o, 1'b0);
    check("rst_level", fifo_level_o, 0);
    rst_i = 1'b0;
    @(negedge clk);

    for (int g = 0; g < 3; g++) begin
      first = -1;
      cnt = 0;
      for (int i = 0; i < 7; i++)
        if (tbl[i].grp == g) begin
          if (first < 0) first = i;
          cnt++;
        end
      clk_div_i   = tbl[first].div;
      parity_en_i = tbl[first].par;
      if (g == 0) begin
        tx_enable_i = 1'b1;
        push(tbl[first].data);
        check("latency_e0", tx_o, 1'b1);
        busy_cnt = 0;
        d0 = done_cnt;
        check_frame(tbl[first].data, tbl[first].div, tbl[first].par, tbl[first].frame, 1,
                    tbl[first].div, tbl[first].par);
        check("busy_cycles", busy_cnt, 40);
        @(negedge clk);
        check("done_count", done_cnt - d0, 1);
      end else begin
        tx_enable_i = 1'b0;
        for (int i = first; i < first + cnt; i++) push(tbl[i].data);
        if (cnt == DEPTH) begin
          check("full_ready", tx_ready_o, 1'b0);
          check("full_level", fifo_level_o, DEPTH);
          push(8'hEE);
          check("overflow_level", fifo_level_o, DEPTH);
        end
        tx_enable_i = 1'b1;
        @(negedge clk);
        check("first_pop_ready", tx_ready_o, 1'b1);
        check("first_pop_level", fifo_level_o, cnt - 1);
        for (int i = first; i < first + cnt; i++) begin
          if (i + 1 < first + cnt)
            check_frame(tbl[i].data, tbl[i].div, tbl[i].par, tbl[i].frame, 0, tbl[i+1].div, tbl[i+1].par);
          else
            check_frame(tbl[i].data, tbl[i].div, tbl[i].par, tbl[i].frame, 0, tbl[i].div, tbl[i].par);
        end
      end
    end

    line_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx_o !== 1'b1) line_ok = 1'b0;
    end
    check("rejected_byte_not_sent", line_ok, 1'b1);
    check("drained_level", fifo_level_o, 0);

    // Drop enable in the middle of data bit 3 of 0x3C.
    tx_enable_i = 1'b0;
    clk_div_i = 32'd3;
    parity_en_i = 1'b0;
    push(8'h3C);
    push(8'h11);
    push(8'h22);
    tx_enable_i = 1'b1;
    @(negedge clk);
    check("abort_start", tx_o, 1'b0);
    repeat (17) @(negedge clk);
    check("abort_bit3_value", tx_o, 1'b1);
    d0 = done_cnt;
    tx_enable_i = 1'b0;
    @(negedge clk);
    check("abort_line_idle", tx_o, 1'b1);
    check("abort_busy", tx_busy_o, 1'b0);
    check("abort_level_kept", fifo_level_o, 2);
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    tx_enable_i = 1'b1;
    check_frame(8'h11, 3, 1'b0, model_frame(8'h11, 1'b0), 1, 3, 1'b0);
    check_frame(8'h22, 3, 1'b0, model_frame(8'h22, 1'b0), 0, 3, 1'b0);
    @(negedge clk);

    // Random bursts; parameters are changed mid-frame to the next frame's values.
    for (int b = 0; b < 10; b++) begin
      nb = $urandom_range(1, DEPTH);
      for (int i = 0; i < nb; i++) begin
        bd[i]   = 8'($urandom);
        bdiv[i] = $urandom_range(0, 5);
        bpar[i] = 1'($urandom);
      end
      tx_enable_i = 1'b0;
      clk_div_i   = bdiv[0];
      parity_en_i = bpar[0];
      for (int i = 0; i < nb; i++) push(bd[i]);
      check("burst_level", fifo_level_o, nb);
      tx_enable_i = 1'b1;
      @(negedge clk);
      for (int i = 0; i < nb; i++) begin
        if (i + 1 < nb)
          check_frame(bd[i], bdiv[i], bpar[i], model_frame(bd[i], bpar[i]), 0, bdiv[i+1], bpar[i+1]);
        else
          check_frame(bd[i], bdiv[i], bpar[i], model_frame(bd[i], bpar[i]), 0, 5 - bdiv[i], !bpar[i]);
      end
      @(negedge clk);
      check("burst_idle", tx_busy_o, 1'b0);
    end

    // Asynchronous reset in the middle of a frame.
    tx_enable_i = 1'b1;
    clk_div_i = 32'd3;
    parity_en_i = 1'b1;
    push(8'h5A);
    push(8'h12);
    n = 0;
    while (tx_o !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    check("pre_reset_busy", tx_busy_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_tx", tx_o, 1'b1);
    check("async_rst_level", fifo_level_o, 0);
    check("async_rst_busy", tx_busy_o, 1'b0);
    check("async_rst_ready", tx_ready_o, 1'b1);
    @(negedge clk);
    rst_i = 1'b0;
    line_ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (tx_o !== 1'b1) line_ok = 1'b0;
    end
    check("post_reset_idle", line_ok, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
